// File: rtl/midi_stream_selector.sv
// Round-robin merger of per-port parsed MIDI messages and sysex byte streams
// into a single byte-wide FIFO stream, with optional running-status compression.
module midi_stream_selector #(
    parameter int NUM_PORTS      = 2,
    parameter int RUNNING_STATUS = 1,
    parameter int SYSCOM_EN      = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_PORTS-1:0]     midi_valid,
    input  logic [4*NUM_PORTS-1:0]   midi_cmd,
    input  logic [4*NUM_PORTS-1:0]   midi_ch,
    input  logic [7*NUM_PORTS-1:0]   midi_data1,
    input  logic [7*NUM_PORTS-1:0]   midi_data2,
    output logic [NUM_PORTS-1:0]     midi_rd,
    output logic [NUM_PORTS-1:0]     midi_busy,
    input  logic [NUM_PORTS-1:0]     sysex_valid,
    input  logic [8*NUM_PORTS-1:0]   sysex_data,
    input  logic [NUM_PORTS-1:0]     sysex_last,
    output logic [NUM_PORTS-1:0]     sysex_rd,
    output logic [NUM_PORTS-1:0]     sysex_busy,
    input  logic                     fifo_wr_rst_busy,
    input  logic                     fifo_busy,
    output logic [7:0]               fifo_in,
    output logic                     fifo_wr
);

    typedef enum logic [1:0] {S_IDLE, S_EX, S_CMD} state_t;

    state_t     state_reg, state_next;
    logic [2:0] g_reg, g_next;
    logic [2:0] ptr_reg, ptr_next;
    logic [1:0] k_reg, k_next;
    logic [7:0] rs_byte_reg, rs_byte_next;
    logic       rs_valid_reg, rs_valid_next;

    // Ports are unpacked into fixed 8-entry arrays so a 3-bit index always fits.
    logic [7:0] mv_a, sxv_a, sxl_a, req_a;
    logic [3:0] cmd_a [8];
    logic [3:0] ch_a  [8];
    logic [6:0] d1_a  [8];
    logic [6:0] d2_a  [8];
    logic [7:0] sxd_a [8];

    logic       fifo_ready;
    logic       rd_midi, rd_sysex;
    logic [2:0] sel;
    logic       sel_found;
    logic [3:0] sel_idx;
    logic [3:0] g_inc;
    logic [2:0] ptr_done;
    logic [3:0] cur_cmd, cur_ch;
    logic [7:0] cur_status;
    logic [1:0] cur_len;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_port
            if (gi < NUM_PORTS) begin : g_used
                assign mv_a[gi]  = midi_valid[gi];
                assign sxv_a[gi] = sysex_valid[gi];
                assign sxl_a[gi] = sysex_last[gi];
                assign cmd_a[gi] = midi_cmd[gi*4 +: 4];
                assign ch_a[gi]  = midi_ch[gi*4 +: 4];
                assign d1_a[gi]  = midi_data1[gi*7 +: 7];
                assign d2_a[gi]  = midi_data2[gi*7 +: 7];
                assign sxd_a[gi] = sysex_data[gi*8 +: 8];
                assign midi_rd[gi]  = rd_midi  && (g_reg == 3'(gi));
                assign sysex_rd[gi] = rd_sysex && (g_reg == 3'(gi));
            end else begin : g_pad
                assign mv_a[gi]  = 1'b0;
                assign sxv_a[gi] = 1'b0;
                assign sxl_a[gi] = 1'b0;
                assign cmd_a[gi] = 4'd0;
                assign ch_a[gi]  = 4'd0;
                assign d1_a[gi]  = 7'd0;
                assign d2_a[gi]  = 7'd0;
                assign sxd_a[gi] = 8'd0;
            end
        end
    endgenerate

    assign req_a      = mv_a | sxv_a;
    assign fifo_ready = ~fifo_wr_rst_busy & ~fifo_busy;
    assign midi_busy  = {NUM_PORTS{fifo_busy}};
    assign sysex_busy = {NUM_PORTS{fifo_busy}};

    assign g_inc      = {1'b0, g_reg} + 4'd1;
    assign ptr_done   = (g_inc == 4'(NUM_PORTS)) ? 3'd0 : g_inc[2:0];
    assign cur_cmd    = cmd_a[g_reg];
    assign cur_ch     = ch_a[g_reg];
    assign cur_status = {cur_cmd, cur_ch};
    assign cur_len    = msg_len(cur_cmd, cur_ch);

    function automatic logic is_chan(input logic [3:0] cmd);
        return (cmd >= 4'h8) && (cmd <= 4'hE);
    endfunction

    function automatic logic [1:0] msg_len(input logic [3:0] cmd, input logic [3:0] ch);
        logic [1:0] len;
        len = 2'd0;
        case (cmd)
            4'h8, 4'h9, 4'hA, 4'hB, 4'hE: len = 2'd3;
            4'hC, 4'hD:                   len = 2'd2;
            4'hF: begin
                if (SYSCOM_EN != 0) begin
                    case (ch)
                        4'h1, 4'h3: len = 2'd2;
                        4'h2:       len = 2'd3;
                        4'h0, 4'h4, 4'h5, 4'h7: len = 2'd0;
                        default:    len = 2'd1;
                    endcase
                end
            end
            default: len = 2'd0;
        endcase
        return len;
    endfunction

    // Round-robin search starting at the pointer, wrapping modulo NUM_PORTS.
    always_comb begin
        sel       = 3'd0;
        sel_found = 1'b0;
        sel_idx   = 4'd0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            sel_idx = {1'b0, ptr_reg} + 4'(i);
            if (sel_idx >= 4'(NUM_PORTS))
                sel_idx = sel_idx - 4'(NUM_PORTS);
            if (!sel_found && req_a[sel_idx[2:0]]) begin
                sel       = sel_idx[2:0];
                sel_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        g_next        = g_reg;
        ptr_next      = ptr_reg;
        k_next        = k_reg;
        rs_byte_next  = rs_byte_reg;
        rs_valid_next = rs_valid_reg;
        fifo_wr       = 1'b0;
        fifo_in       = 8'd0;
        rd_midi       = 1'b0;
        rd_sysex      = 1'b0;
        if (fifo_wr_rst_busy) begin
            // FIFO restart: abandon the message; it is re-sent in full afterwards.
            state_next    = S_IDLE;
            rs_valid_next = 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (sel_found) begin
                        g_next = sel;
                        k_next = ((RUNNING_STATUS != 0) && is_chan(cmd_a[sel]) && rs_valid_reg
                                  && ({cmd_a[sel], ch_a[sel]} == rs_byte_reg)) ? 2'd1 : 2'd0;
                        state_next = sxv_a[sel] ? S_EX : S_CMD;
                    end
                end
                S_EX: begin
                    if (fifo_ready && sxv_a[g_reg]) begin
                        fifo_wr       = 1'b1;
                        fifo_in       = sxd_a[g_reg];
                        rd_sysex      = 1'b1;
                        rs_valid_next = 1'b0;
                        if (sxl_a[g_reg]) begin
                            state_next = S_IDLE;
                            ptr_next   = ptr_done;
                        end
                    end
                end
                S_CMD: begin
                    if (cur_len == 2'd0) begin
                        rd_midi    = 1'b1;
                        state_next = S_IDLE;
                        ptr_next   = ptr_done;
                    end else if (fifo_ready && mv_a[g_reg]) begin
                        fifo_wr = 1'b1;
                        case (k_reg)
                            2'd0:    fifo_in = cur_status;
                            2'd1:    fifo_in = {1'b0, d1_a[g_reg]};
                            default: fifo_in = {1'b0, d2_a[g_reg]};
                        endcase
                        if (k_reg == 2'd0) begin
                            if (is_chan(cur_cmd)) begin
                                rs_byte_next  = cur_status;
                                rs_valid_next = 1'b1;
                            end else if (cur_cmd == 4'hF && !cur_ch[3]) begin
                                rs_valid_next = 1'b0;
                            end
                        end
                        if (k_reg == cur_len - 2'd1) begin
                            rd_midi    = 1'b1;
                            state_next = S_IDLE;
                            ptr_next   = ptr_done;
                        end else begin
                            k_next = k_reg + 2'd1;
                        end
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            g_reg        <= 3'd0;
            ptr_reg      <= 3'd0;
            k_reg        <= 2'd0;
            rs_byte_reg  <= 8'd0;
            rs_valid_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            g_reg        <= g_next;
            ptr_reg      <= ptr_next;
            k_reg        <= k_next;
            rs_byte_reg  <= rs_byte_next;
            rs_valid_reg <= rs_valid_next;
        end
    end

endmodule

// File: tb/tb_midi_stream_selector.sv
// Directed bench for midi_stream_selector: per-port message queues feed the
// DUT, the output byte stream and completion pulses are logged and compared.
module tb_midi_stream_selector;

    typedef struct packed {
        logic       sx;
        logic       last;
        logic [7:0] b;
        logic [6:0] d1;
        logic [6:0] d2;
    } item_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  midi_valid = '0;
    logic [7:0]  midi_cmd = '0;
    logic [7:0]  midi_ch = '0;
    logic [13:0] midi_data1 = '0;
    logic [13:0] midi_data2 = '0;
    logic [1:0]  sysex_valid = '0;
    logic [15:0] sysex_data = '0;
    logic [1:0]  sysex_last = '0;
    logic        fifo_wr_rst_busy = 1'b0;
    logic        fifo_busy = 1'b0;

    logic [1:0]  midi_rd, midi_busy, sysex_rd, sysex_busy;
    logic [7:0]  fifo_in;
    logic        fifo_wr;
    logic [1:0]  midi_rd2, midi_busy2, sysex_rd2, sysex_busy2;
    logic [7:0]  fifo_in2;
    logic        fifo_wr2;

    always #5 clk = ~clk;

    midi_stream_selector dut (
        .clk(clk), .rst(rst),
        .midi_valid(midi_valid), .midi_cmd(midi_cmd), .midi_ch(midi_ch),
        .midi_data1(midi_data1), .midi_data2(midi_data2),
        .midi_rd(midi_rd), .midi_busy(midi_busy),
        .sysex_valid(sysex_valid), .sysex_data(sysex_data), .sysex_last(sysex_last),
        .sysex_rd(sysex_rd), .sysex_busy(sysex_busy),
        .fifo_wr_rst_busy(fifo_wr_rst_busy), .fifo_busy(fifo_busy),
        .fifo_in(fifo_in), .fifo_wr(fifo_wr)
    );

    midi_stream_selector #(.RUNNING_STATUS(0)) dut_nrs (
        .clk(clk), .rst(rst),
        .midi_valid(midi_valid), .midi_cmd(midi_cmd), .midi_ch(midi_ch),
        .midi_data1(midi_data1), .midi_data2(midi_data2),
        .midi_rd(midi_rd2), .midi_busy(midi_busy2),
        .sysex_valid(sysex_valid), .sysex_data(sysex_data), .sysex_last(sysex_last),
        .sysex_rd(sysex_rd2), .sysex_busy(sysex_busy2),
        .fifo_wr_rst_busy(fifo_wr_rst_busy), .fifo_busy(fifo_busy),
        .fifo_in(fifo_in2), .fifo_wr(fifo_wr2)
    );

    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;
    int         busy_lo = -1, busy_hi = -2;
    int         rb_lo = -1, rb_hi = -2;
    bit         hold = 1'b0;
    item_t      pq [2][$];
    logic [7:0] out_b [$];
    logic [7:0] out2_b [$];
    int         out_c [$];
    int         rd_c [$];
    int         rd_p [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic check_q(input string tag, input logic [7:0] got [$], input logic [7:0] exp [$]);
        for (int i = 0; i < exp.size(); i++)
            check($sformatf("%s[%0d]", tag, i), (i < got.size()) ? 32'(got[i]) : 32'hDEAD, 32'(exp[i]));
    endtask

    task automatic check_iq(input string tag, input int got [$], input int exp [$]);
        check($sformatf("%s.len", tag), got.size(), exp.size());
        for (int i = 0; i < exp.size(); i++)
            check($sformatf("%s[%0d]", tag, i), (i < got.size()) ? got[i] : 32'hDEAD, exp[i]);
    endtask

    task automatic push_msg(input int p, input logic [7:0] st, input logic [6:0] d1, input logic [6:0] d2);
        item_t it;
        it = '{sx: 1'b0, last: 1'b0, b: st, d1: d1, d2: d2};
        pq[p].push_back(it);
    endtask

    task automatic push_sx(input int p, input logic [7:0] b, input logic last);
        item_t it;
        it = '{sx: 1'b1, last: last, b: b, d1: 7'd0, d2: 7'd0};
        pq[p].push_back(it);
    endtask

    task automatic drive();
        item_t h;
        fifo_busy        = (cyc >= busy_lo) && (cyc <= busy_hi);
        fifo_wr_rst_busy = (cyc >= rb_lo) && (cyc <= rb_hi);
        for (int p = 0; p < 2; p++) begin
            midi_valid[p]  = 1'b0;
            sysex_valid[p] = 1'b0;
            sysex_last[p]  = 1'b0;
            if (pq[p].size() != 0) begin
                h = pq[p][0];
                if (h.sx) begin
                    sysex_valid[p]        = 1'b1;
                    sysex_last[p]         = h.last;
                    sysex_data[p*8 +: 8]  = h.b;
                end else begin
                    midi_valid[p]         = 1'b1;
                    midi_cmd[p*4 +: 4]    = h.b[7:4];
                    midi_ch[p*4 +: 4]     = h.b[3:0];
                    midi_data1[p*7 +: 7]  = h.d1;
                    midi_data2[p*7 +: 7]  = h.d2;
                end
            end
        end
    endtask

    task automatic clear_logs();
        out_b.delete(); out2_b.delete(); out_c.delete(); rd_c.delete(); rd_p.delete();
    endtask

    // One clock: sample on the falling edge, advance the port queues after the rising edge.
    task automatic step();
        logic [1:0] mrd, srd, slast;
        @(negedge clk);
        mrd = midi_rd; srd = sysex_rd; slast = sysex_last;
        if (fifo_wr) begin
            out_b.push_back(fifo_in);
            out_c.push_back(cyc);
        end
        if (fifo_wr2) out2_b.push_back(fifo_in2);
        for (int p = 0; p < 2; p++)
            if (mrd[p] || (srd[p] && slast[p])) begin
                rd_c.push_back(cyc);
                rd_p.push_back(p);
            end
        @(posedge clk);
        #1;
        cyc++;
        if (!hold)
            for (int p = 0; p < 2; p++)
                if ((mrd[p] || srd[p]) && pq[p].size() != 0) pq[p].delete(0);
        drive();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pq[0].delete(); pq[1].delete();
        clear_logs();
        busy_lo = -1; busy_hi = -2; rb_lo = -1; rb_hi = -2;
        hold = 1'b0;
        cyc = 0;
        drive();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((pq[0].size() + pq[1].size()) != 0 && n < budget) begin
            step();
            n++;
        end
        check("drain", pq[0].size() + pq[1].size(), 0);
        step();
        step();
    endtask

    logic [7:0] exp_b [$];
    logic [7:0] exp_b2 [$];

    initial begin
        // Reset values with a request pending and the FIFO busy
        do_reset();
        rst = 1'b1;
        push_msg(0, 8'h90, 7'h3C, 7'h64);
        busy_lo = 0; busy_hi = 0;
        drive();
        @(negedge clk);
        check("rst_fifo_wr", fifo_wr, 0);
        check("rst_fifo_in", fifo_in, 0);
        check("rst_midi_rd", midi_rd, 0);
        check("rst_sysex_rd", sysex_rd, 0);
        check("midi_busy_hi", midi_busy, 2'b11);
        check("sysex_busy_hi", sysex_busy, 2'b11);
        fifo_busy = 1'b0;
        #1;
        check("midi_busy_lo", midi_busy, 2'b00);

        // Single note-on: one grant cycle, then three bytes
        do_reset();
        push_msg(0, 8'h90, 7'h3C, 7'h64);
        drive();
        drain(20);
        exp_b = {8'h90, 8'h3C, 8'h64};
        check("single.len", out_b.size(), 3);
        check_q("single", out_b, exp_b);
        check_iq("single.wrcyc", out_c, {1, 2, 3});
        check_iq("single.rdcyc", rd_c, {3});
        check_iq("single.rdport", rd_p, {0});

        // Repeated message held valid: running status vs. full status
        do_reset();
        hold = 1'b1;
        push_msg(0, 8'h90, 7'h3C, 7'h64);
        drive();
        repeat (10) step();
        exp_b  = {8'h90, 8'h3C, 8'h64, 8'h3C, 8'h64, 8'h3C};
        exp_b2 = {8'h90, 8'h3C, 8'h64, 8'h90, 8'h3C, 8'h64};
        check_q("rs_on", out_b, exp_b);
        check_q("rs_off", out2_b, exp_b2);
        hold = 1'b0;

        // Two busy ports alternate; sysex on port1 stays contiguous
        do_reset();
        push_msg(0, 8'h90, 7'h3C, 7'h64);
        push_msg(0, 8'h90, 7'h3C, 7'h64);
        push_sx(1, 8'hF0, 1'b0);
        push_sx(1, 8'h01, 1'b0);
        push_sx(1, 8'hF7, 1'b1);
        push_msg(1, 8'hA1, 7'h40, 7'h10);
        drive();
        drain(60);
        exp_b = {8'h90, 8'h3C, 8'h64, 8'hF0, 8'h01, 8'hF7, 8'h90, 8'h3C, 8'h64, 8'hA1, 8'h40, 8'h10};
        check("rr.len", out_b.size(), 12);
        check_q("rr", out_b, exp_b);
        check_iq("rr.order", rd_p, {0, 1, 0, 1});

        // Realtime F8 keeps running status
        do_reset();
        push_msg(0, 8'h90, 7'h3C, 7'h64);
        push_msg(0, 8'hF8, 7'h00, 7'h00);
        push_msg(0, 8'h90, 7'h3C, 7'h40);
        drive();
        drain(40);
        exp_b = {8'h90, 8'h3C, 8'h64, 8'hF8, 8'h3C, 8'h40};
        check("f8.len", out_b.size(), 6);
        check_q("f8", out_b, exp_b);

        // Tune request F6 cancels running status
        do_reset();
        push_msg(0, 8'h90, 7'h3C, 7'h64);
        push_msg(0, 8'hF6, 7'h00, 7'h00);
        push_msg(0, 8'h90, 7'h3C, 7'h40);
        drive();
        drain(40);
        exp_b = {8'h90, 8'h3C, 8'h64, 8'hF6, 8'h90, 8'h3C, 8'h40};
        check("f6.len", out_b.size(), 7);
        check_q("f6", out_b, exp_b);

        // FIFO busy for four cycles after the second byte
        do_reset();
        busy_lo = 3; busy_hi = 6;
        push_msg(0, 8'hB0, 7'h07, 7'h7F);
        drive();
        drain(30);
        exp_b = {8'hB0, 8'h07, 8'h7F};
        check_q("stall", out_b, exp_b);
        check_iq("stall.wrcyc", out_c, {1, 2, 7});
        check_iq("stall.rdcyc", rd_c, {7});

        // FIFO reset pulse mid-message forces a full resend
        do_reset();
        rb_lo = 2; rb_hi = 2;
        push_msg(0, 8'hC5, 7'h10, 7'h00);
        drive();
        drain(30);
        exp_b = {8'hC5, 8'hC5, 8'h10};
        check("abort.len", out_b.size(), 3);
        check_q("abort", out_b, exp_b);
        check_iq("abort.wrcyc", out_c, {1, 4, 5});
        check_iq("abort.rdcyc", rd_c, {5});

        // Undefined system code F4 is consumed without output
        do_reset();
        push_msg(0, 8'hF4, 7'h00, 7'h00);
        push_msg(0, 8'h90, 7'h3C, 7'h64);
        drive();
        drain(30);
        exp_b = {8'h90, 8'h3C, 8'h64};
        check("drop.len", out_b.size(), 3);
        check_q("drop", out_b, exp_b);
        check_iq("drop.rdcyc", rd_c, {1, 5});

        // Reset asserted mid-message drops it; resent after release
        do_reset();
        push_msg(0, 8'hB0, 7'h07, 7'h7F);
        drive();
        step();
        step();
        rst = 1'b1;
        #1;
        check("midrst_fifo_wr", fifo_wr, 0);
        check("midrst_midi_rd", midi_rd, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        clear_logs();
        drive();
        drain(30);
        exp_b = {8'hB0, 8'h07, 8'h7F};
        check("midrst.len", out_b.size(), 3);
        check_q("midrst", out_b, exp_b);
        check_iq("midrst.rdcyc", rd_c, {3});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/midi_stream_selector.md
MIDI_STREAM_SELECTOR -- requirements
Module: midi_stream_selector

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2, number of MIDI bus input ports (1..8).
REQ-002 SHALL have parameter RUNNING_STATUS, default 1, where 1 enables running-status compression of channel-message status bytes.
REQ-003 SHALL have parameter SYSCOM_EN, default 1, where 1 serialises system common/realtime messages and 0 drops them.
REQ-004 clk  in  1  single clock; all logic on posedge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 midi_valid  in  NUM_PORTS  per-port parsed message present.
REQ-007 midi_cmd  in  4*NUM_PORTS  per-port status high nibble.
REQ-008 midi_ch  in  4*NUM_PORTS  per-port status low nibble (channel, or system code when cmd=F).
REQ-009 midi_data1  in  7*NUM_PORTS  per-port first data byte.
REQ-010 midi_data2  in  7*NUM_PORTS  per-port second data byte.
REQ-011 midi_rd  out  NUM_PORTS  one-cycle pulse that consumes the port's message.
REQ-012 midi_busy  out  NUM_PORTS  every bit equals fifo_busy.
REQ-013 sysex_valid  in  NUM_PORTS  per-port sysex byte present.
REQ-014 sysex_data  in  8*NUM_PORTS  per-port sysex byte.
REQ-015 sysex_last  in  NUM_PORTS  per-port final sysex byte marker.
REQ-016 sysex_rd  out  NUM_PORTS  per-port sysex byte consumed.
REQ-017 sysex_busy  out  NUM_PORTS  every bit equals fifo_busy.
REQ-018 fifo_wr_rst_busy  in  1  output FIFO in reset.
REQ-019 fifo_busy  in  1  output FIFO cannot accept data.
REQ-020 fifo_in  out  8  byte to FIFO.
REQ-021 fifo_wr  out  1  write strobe; at most one byte per cycle.

Function
REQ-022 SHALL define fifo_ready = ~fifo_wr_rst_busy & ~fifo_busy, and SHALL assert fifo_wr only when fifo_ready.
REQ-023 SHALL implement states S_IDLE, S_EX and S_CMD with a registered grant index g.
REQ-024 S_IDLE SHALL grant the first requesting port (sysex_valid|midi_valid) at or after the round-robin pointer, enter S_EX if sysex_valid[g] else S_CMD, and register g on the next edge without writing.
REQ-025 In S_EX, SHALL on each cycle with fifo_ready & sysex_valid[g] pulse sysex_rd[g] and fifo_wr with fifo_in=sysex_data[g]; a write with sysex_last[g] SHALL return to S_IDLE.
REQ-026 The message length L SHALL be 3 for cmd 8,9,A,B,E and 2 for cmd C,D.
REQ-027 With SYSCOM_EN=1, L SHALL be 2 for F1/F3, 3 for F2, 1 for F6 and F8-FF; F0, F4, F5, F7 and every F-code with SYSCOM_EN=0 SHALL give L=0.
REQ-028 In S_CMD, SHALL emit bytes status, data1, data2 (data zero-extended to 8 bits) for index k=start..L-1, one per cycle with fifo_ready & midi_valid[g].
REQ-029 SHALL pulse midi_rd[g] together with the last byte's fifo_wr and then return to S_IDLE; for L=0, SHALL pulse midi_rd[g] in the first S_CMD cycle with no write.
REQ-030 start SHALL be 1 when RUNNING_STATUS=1, cmd is 8..E, and the status equals rs_byte with rs_valid set; otherwise start SHALL be 0.
REQ-031 rs_byte/rs_valid SHALL be set by each emitted channel status byte and cleared by any sysex byte or F0-F7 emission; F8-FF SHALL leave them unchanged.
REQ-032 On message completion, the pointer SHALL become (g+1) mod NUM_PORTS and S_IDLE SHALL be re-entered for one cycle.
REQ-033 The port of a message in progress SHALL hold its inputs stable until rd; a request from any other port SHALL NOT pre-empt the grant.
REQ-034 fifo_busy mid-message SHALL stall the index with no write and no rd pulse.
REQ-035 fifo_wr_rst_busy SHALL force S_IDLE on the next edge, abort the current message with no rd, clear rs_valid, leave the pointer unchanged, and cause the aborted message to be resent in full.

Reset
REQ-036 While rst is high, SHALL hold state=S_IDLE, pointer=0, g=0, rs_valid=0, fifo_wr=0, fifo_in=0, and all midi_rd/sysex_rd=0.
REQ-037 Reset assertion mid-message SHALL drop the message immediately, and the first cycle after release SHALL behave as S_IDLE.

Verification
REQ-038 Port0 sends 90 3C 64, FIFO ready -> bytes 90,3C,64 on three consecutive cycles after a one-cycle grant, with midi_rd[0] on the third byte.
REQ-039 Port0 sends 90 3C 64 twice -> second message writes 3C,64 only; with RUNNING_STATUS=0, all six bytes are written.
REQ-040 Both ports valid continuously -> grants alternate 0,1,0,1; a sysex (F0 01 F7) on port1 is never interleaved.
REQ-041 F8 between two 90 messages -> output 90 3C 64 F8 3C 40 (running status kept); F6 between them -> 90 status resent.
REQ-042 fifo_busy is high for 4 cycles after the second byte of B0 07 7F -> no writes during the stall, then 7F is written and midi_rd pulses once.
REQ-043 fifo_wr_rst_busy pulses mid-message on C5 10 -> no midi_rd pulse; C5,10 is written in full after release.
